// File: rtl/uart_pkg.sv
// Shared types and constants for the UART loopback transmit path.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_FRAME_BITS = 10;

    // Clock cycles per bit at a 1x baud divider (integer division).
    function automatic int unsigned uart_div(input int unsigned clk_freq,
                                             input int unsigned baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO. A push while full is ignored; a pop while empty is ignored.
// Head data is presented combinationally on rdata_o.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_MAX);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy next-state; power-of-2 depth lets pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_loopback_tx.sv
// UART transmit side of the loopback: buffers received bytes and sends them
// as 8N1 frames, LSB first, with back-to-back frames when the FIFO has data.
module uart_loopback_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          data_ready,
    input  logic [UART_DATA_BITS-1:0]     data,
    output logic                          TxD,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD);
    localparam int unsigned BW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [2:0]    BIT_LAST  = 3'(UART_DATA_BITS - 1);

    tx_state_t                 state_q, state_d;
    logic [BW-1:0]             baud_q, baud_d;
    logic [2:0]                bit_q, bit_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      txd_q, txd_d;
    logic                      ovf_q, ovf_d;
    logic                      baud_last;
    logic                      fifo_pop;
    logic                      fifo_full, fifo_empty;
    logic [UART_DATA_BITS-1:0] fifo_head;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (data_ready),
        .wdata_i (data),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_last = (baud_q == BAUD_LAST);
    assign TxD       = txd_q;
    assign overflow  = ovf_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

    // Sticky overflow: judged on occupancy before any same-cycle pop.
    assign ovf_d = ovf_q | (data_ready & fifo_full);

    // Frame sequencer: next state, bit timing, shift register and line level.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_last ? '0 : baud_q + BAUD_ONE;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                baud_d = '0;
                txd_d  = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    state_d  = START;
                    txd_d    = 1'b0;
                end
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end
            end
            DATA: begin
                if (baud_last) begin
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        txd_d   = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (baud_last) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        state_d  = START;
                        txd_d    = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        txd_d    = 1'b1;
                    end
                end
            end
        endcase
    end

    // Sequencer and status registers; the line idles high out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_uart_loopback_tx.sv
// Bench for uart_loopback_tx: a line monitor decodes frames and compares them
// against a queue of expected bytes filled when strobes are driven.
module tb_uart_loopback_tx;
    import uart_pkg::*;

    localparam int unsigned CLK_FREQ   = 1_000_000;
    localparam int unsigned BAUD       = 100_000;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int          DIV        = CLK_FREQ / BAUD;
    localparam int          FRAME      = UART_FRAME_BITS * DIV;
    localparam int          BUDGET     = 2000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       data_ready = 1'b0;
    logic [7:0] data = '0;
    logic       TxD, busy, overflow;
    logic [3:0] fifo_count;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    logic       mon_active = 1'b0;
    logic       prev_txd = 1'b1;
    int         mon_phase = 0;
    logic [9:0] mon_bits = '0;

    uart_loopback_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_ready (data_ready),
        .data       (data),
        .TxD        (TxD),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line monitor: detect start, sample mid-bit, compare finished frames.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_active = 1'b0;
            prev_txd   = 1'b1;
        end else if (!mon_active) begin
            if (prev_txd === 1'b1 && TxD === 1'b0) begin
                mon_active = 1'b1;
                mon_phase  = 0;
                start_q.push_back(cyc);
            end
            prev_txd = TxD;
        end else begin
            mon_phase++;
            if (mon_phase % DIV == DIV / 2) mon_bits[mon_phase / DIV] = TxD;
            if (mon_phase == FRAME - DIV / 2) begin
                mon_active = 1'b0;
                checks++;
                if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) begin
                    errors++;
                    $display("FAIL frame_framing: start=%b stop=%b, required start=0 stop=1",
                             mon_bits[0], mon_bits[9]);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL frame_unexpected: got byte %02h, required no frame", mon_bits[8:1]);
                end else begin
                    automatic logic [7:0] exp_b = exp_q.pop_front();
                    if (mon_bits[8:1] !== exp_b) begin
                        errors++;
                        $display("FAIL frame_data: got %02h, required %02h", mon_bits[8:1], exp_b);
                    end
                end
            end
            prev_txd = TxD;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic strobe(input logic [7:0] b, input bit expect_tx);
        data       = b;
        data_ready = 1'b1;
        if (expect_tx) exp_q.push_back(b);
        @(negedge clk);
        data_ready = 1'b0;
    endtask

    task automatic wait_idle(output int fall_cyc);
        int n = 0;
        while (busy !== 1'b0 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        fall_cyc = cyc;
        checks++;
        if (n >= BUDGET) begin
            errors++;
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drained: %0d frames outstanding, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        bit stayed_high = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (TxD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b, required 1", TxD); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, required 0", overflow); end
        checks++;
        if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
        repeat (200) begin
            @(negedge clk);
            if (TxD !== 1'b1) stayed_high = 1'b0;
        end
        checks++;
        if (!stayed_high || start_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle_line: high=%b starts=%0d, required high=1 starts=0",
                     stayed_high, start_q.size());
        end
    endtask

    task automatic test_single();
        int sc, fall;
        start_q.delete();
        strobe(8'hA5, 1'b1);
        sc = cyc;
        checks++;
        if (fifo_count !== 4'd1) begin errors++; $display("FAIL single_count: got %0d, required 1", fifo_count); end
        wait_idle(fall);
        check_drained("single");
        checks++;
        if (start_q.size() != 1) begin
            errors++;
            $display("FAIL single_starts: got %0d, required 1", start_q.size());
        end else begin
            checks++;
            if (start_q[0] - sc != 1) begin
                errors++;
                $display("FAIL single_latency: got %0d, required 1", start_q[0] - sc);
            end
            checks++;
            if (fall - start_q[0] != FRAME) begin
                errors++;
                $display("FAIL single_busy_len: got %0d, required %0d", fall - start_q[0], FRAME);
            end
        end
    endtask

    task automatic test_back_to_back();
        int fall, n;
        logic [3:0] c1, c2;
        start_q.delete();
        data = 8'h00; data_ready = 1'b1; exp_q.push_back(8'h00);
        @(negedge clk);
        c1 = fifo_count;
        // Second push lands on the same edge that pops 0x00.
        data = 8'hFF; exp_q.push_back(8'hFF);
        @(negedge clk);
        data_ready = 1'b0;
        c2 = fifo_count;
        checks++;
        if (c1 !== 4'd1 || c2 !== 4'd1) begin
            errors++;
            $display("FAIL b2b_count_fill: got %0d,%0d, required 1,1", c1, c2);
        end
        n = 0;
        while (start_q.size() < 2 && n < BUDGET) begin @(negedge clk); n++; end
        checks++;
        if (fifo_count !== 4'd0) begin errors++; $display("FAIL b2b_count_empty: got %0d, required 0", fifo_count); end
        wait_idle(fall);
        check_drained("b2b");
        checks++;
        if (start_q.size() != 2) begin
            errors++;
            $display("FAIL b2b_starts: got %0d, required 2", start_q.size());
        end else begin
            checks++;
            if (start_q[1] - start_q[0] != FRAME) begin
                errors++;
                $display("FAIL b2b_gap: got %0d, required %0d", start_q[1] - start_q[0], FRAME);
            end
        end
    endtask

    task automatic test_overflow();
        int fall;
        for (int i = 1; i <= 10; i++) begin
            data       = 8'(i);
            data_ready = 1'b1;
            if (i <= 9) exp_q.push_back(8'(i));
            @(negedge clk);
            if (i == 9) begin
                checks++;
                if (fifo_count !== 4'd8 || overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL ovf_full: count=%0d ovf=%b, required count=8 ovf=0", fifo_count, overflow);
                end
            end
        end
        data_ready = 1'b0;
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drop: count=%0d ovf=%b, required count=8 ovf=1", fifo_count, overflow);
        end
        wait_idle(fall);
        check_drained("ovf");
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, required 1", overflow); end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b, required 0", overflow); end
    endtask

    task automatic test_collision();
        int fall, tgt, n;
        start_q.delete();
        strobe(8'h11, 1'b1);
        strobe(8'h22, 1'b1);
        strobe(8'h33, 1'b1);
        strobe(8'h44, 1'b1);
        checks++;
        if (fifo_count !== 4'd3) begin errors++; $display("FAIL coll_fill: got %0d, required 3", fifo_count); end
        n = 0;
        while (start_q.size() < 1 && n < BUDGET) begin @(negedge clk); n++; end
        tgt = (start_q.size() > 0) ? start_q[0] + FRAME - 1 : cyc;
        while (cyc < tgt) @(negedge clk);
        strobe(8'h55, 1'b1);
        checks++;
        if (fifo_count !== 4'd3) begin errors++; $display("FAIL coll_count: got %0d, required 3", fifo_count); end
        wait_idle(fall);
        check_drained("coll");
        checks++;
        if (start_q.size() != 5) begin
            errors++;
            $display("FAIL coll_starts: got %0d, required 5", start_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit stayed_high = 1'b1;
        start_q.delete();
        strobe(8'h3C, 1'b1);
        repeat (44) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b, required 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (TxD !== 1'b1 || fifo_count !== 4'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: txd=%b count=%0d busy=%b, required txd=1 count=0 busy=0",
                     TxD, fifo_count, busy);
        end
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (TxD !== 1'b1) stayed_high = 1'b0;
        end
        checks++;
        if (!stayed_high || start_q.size() != 1 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL mid_no_resume: high=%b starts=%0d count=%0d, required high=1 starts=1 count=0",
                     stayed_high, start_q.size(), fifo_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_collision();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
